// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads instruction words at the PC, holds them for the control unit and follows jumps.
// Optional memory-timeout watchdog is enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [2:0]        op,
  output logic [DATA_W-4:0] operand,
  output logic              op_valid,
  input  logic              en_fetch,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshakes: mem_rd/mem_ack is a request held high until an ack is sampled
  // in the same cycle; op_valid/en_fetch is valid/ready, a word transfers on
  // the edge where both are high; jmp overrides both handshakes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-4:0]   operand_q, operand_d;
  logic                op_valid_q, op_valid_d;
  logic                drop_live;
  logic                rd_live;

  assign rd_live = (state_q == FETCH) && !drop_live;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    operand_d  = operand_q;
    op_valid_d = op_valid_q;
    if (jmp) begin
      pc_d       = jmp_addr;
      op_valid_d = 1'b0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (rd_live && mem_ack) begin
            op_d       = mem_data[DATA_W-1:DATA_W-3];
            operand_d  = mem_data[DATA_W-4:0];
            op_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = VALID;
          end
        end
        VALID: begin
          if (en_fetch) begin
            op_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      op_q       <= '0;
      operand_q  <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      op_valid_q <= op_valid_d;
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;

  // The counter sits at zero outside FETCH, so every entry into FETCH starts
  // a fresh 16-cycle window; the drop cycle abandons the read before retrying.
  always_comb begin
    cnt_d  = cnt_q;
    err_d  = err_q;
    drop_d = 1'b0;
    if (jmp || state_q != FETCH) begin
      cnt_d = '0;
    end else if (drop_q || mem_ack) begin
      cnt_d = '0;
    end else if (cnt_q == 4'hF) begin
      err_d  = 1'b1;
      drop_d = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign drop_live = drop_q;
  assign err       = err_q;
`else
  assign drop_live = 1'b0;
  assign err       = 1'b0;
`endif

  assign mem_rd    = rd_live;
  assign mem_addr  = pc_q;
  assign op        = op_q;
  assign operand   = operand_q;
  assign op_valid  = op_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a transaction-level model.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [2:0]    op;
  logic [DW-4:0] operand;
  logic          op_valid;
  logic          en_fetch;
  logic          jmp;
  logic [AW-1:0] jmp_addr;
  logic          err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clr(clr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .op(op), .operand(operand),
    .op_valid(op_valid), .en_fetch(en_fetch), .jmp(jmp), .jmp_addr(jmp_addr),
    .err(err), .dbg_state(dbg_state)
  );

  // Transaction-level model: what the fetch unit is doing, not how it encodes it.
  typedef struct {
    logic       idle;
    logic       fetching;
    logic       have;
    logic       drop;
    logic       err;
    logic [7:0] pc;
    logic [2:0] op;
    logic [4:0] operand;
    int         miss;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t rst_mdl();
    mdl_t r;
    r.idle = 1'b1; r.fetching = 1'b0; r.have = 1'b0; r.drop = 1'b0; r.err = 1'b0;
    r.pc = 8'h00; r.op = 3'd0; r.operand = 5'd0; r.miss = 0;
    return r;
  endfunction

  function automatic mdl_t next_mdl(input mdl_t s, input logic a, input logic [7:0] d,
                                    input logic e, input logic j, input logic [7:0] ja);
    mdl_t n;
    n = s;
    if (j) begin
      n.pc = ja; n.have = 1'b0; n.fetching = 1'b1; n.idle = 1'b0; n.miss = 0; n.drop = 1'b0;
    end else if (s.idle) begin
      n.idle = 1'b0; n.fetching = 1'b1; n.miss = 0;
    end else if (s.fetching) begin
      if (s.drop) begin
        n.drop = 1'b0; n.miss = 0;
      end else if (a) begin
        n.op = d[7:5]; n.operand = d[4:0]; n.have = 1'b1; n.fetching = 1'b0;
        n.pc = s.pc + 8'd1;
      end else begin
        n.miss = s.miss + 1;
`ifdef INSTR_FETCH_TIMEOUT_EN
        if (n.miss == 16) begin
          n.err = 1'b1; n.drop = 1'b1; n.miss = 0;
        end
`endif
      end
    end else if (s.have && e) begin
      n.have = 1'b0; n.fetching = 1'b1; n.miss = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) m <= rst_mdl();
    else     m <= next_mdl(m, mem_ack, mem_data, en_fetch, jmp, jmp_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mem_rd",   32'(mem_rd),   32'(m.fetching && !m.drop));
    chk("mem_addr", 32'(mem_addr), 32'(m.pc));
    chk("op",       32'(op),       32'(m.op));
    chk("operand",  32'(operand),  32'(m.operand));
    chk("op_valid", 32'(op_valid), 32'(m.have));
    chk("err",      32'(err),      32'(m.err));
  end

  task automatic step(input logic a, input logic [7:0] d, input logic e,
                      input logic j, input logic [7:0] ja);
    mem_ack = a; mem_data = d; en_fetch = e; jmp = j; jmp_addr = ja;
    @(posedge clk);
    #3;
  endtask

  initial begin
    clr = 1'b0; mem_ack = 1'b0; mem_data = '0; en_fetch = 1'b0; jmp = 1'b0; jmp_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #1 clr = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_operand", 32'(operand), 0);
    chk("rst_op_valid", 32'(op_valid), 0);
    chk("rst_err", 32'(err), 0);
    clr = 1'b0;
    #1 chk("idle_mem_rd", 32'(mem_rd), 0);

    step(0, 8'h00, 0, 0, 8'h00);
    chk("fetch0_rd", 32'(mem_rd), 1);
    chk("fetch0_addr", 32'(mem_addr), 0);
    step(0, 8'h00, 0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 8'h00);
    step(1, 8'hA5, 0, 0, 8'h00);
    chk("a5_op", 32'(op), 3'b101);
    chk("a5_operand", 32'(operand), 5'h05);
    chk("a5_valid", 32'(op_valid), 1);
    chk("a5_pc", 32'(mem_addr), 1);
    chk("a5_rd", 32'(mem_rd), 0);

    for (int i = 0; i < 10; i++) begin
      step(1'(i % 2), 8'h3C, 0, 0, 8'h00);
      chk("hold_op", 32'(op), 3'b101);
      chk("hold_operand", 32'(operand), 5'h05);
      chk("hold_valid", 32'(op_valid), 1);
      chk("hold_rd", 32'(mem_rd), 0);
    end
    step(0, 8'h00, 1, 0, 8'h00);
    chk("consume_valid", 32'(op_valid), 0);
    chk("consume_rd", 32'(mem_rd), 1);
    chk("consume_addr", 32'(mem_addr), 1);
    chk("retain_op", 32'(op), 3'b101);

    step(0, 8'h00, 0, 1, 8'hFF);
    chk("jmp_ff_addr", 32'(mem_addr), 8'hFF);
    step(1, 8'h27, 0, 0, 8'h00);
    chk("wrap_op", 32'(op), 3'd1);
    chk("wrap_operand", 32'(operand), 5'h07);
    chk("wrap_pc", 32'(mem_addr), 8'h00);
    step(0, 8'h00, 1, 0, 8'h00);
    chk("wrap_rd", 32'(mem_rd), 1);
    chk("wrap_addr", 32'(mem_addr), 8'h00);

    step(1, 8'hFF, 1, 1, 8'h40);
    chk("jmp_discard_valid", 32'(op_valid), 0);
    chk("jmp_discard_op", 32'(op), 3'd1);
    chk("jmp_addr_40", 32'(mem_addr), 8'h40);
    chk("jmp_rd", 32'(mem_rd), 1);
    step(1, 8'h81, 0, 0, 8'h00);
    chk("j40_op", 32'(op), 3'd4);
    chk("j40_addr", 32'(mem_addr), 8'h41);
    step(0, 8'h00, 1, 1, 8'h10);
    chk("jmp_valid_clr", 32'(op_valid), 0);
    chk("jmp_valid_addr", 32'(mem_addr), 8'h10);

    clr = 1'b1;
    #1;
    chk("clr_rd", 32'(mem_rd), 0);
    chk("clr_addr", 32'(mem_addr), 0);
    chk("clr_op", 32'(op), 0);
    chk("clr_operand", 32'(operand), 0);
    chk("clr_valid", 32'(op_valid), 0);
    step(1, 8'hE1, 0, 0, 8'h00);
    clr = 1'b0;
    #1 chk("post_clr_rd", 32'(mem_rd), 0);
    step(1, 8'hE1, 0, 0, 8'h00);
    chk("stray_valid", 32'(op_valid), 0);
    chk("stray_op", 32'(op), 0);
    chk("stray_rd", 32'(mem_rd), 1);
    chk("stray_addr", 32'(mem_addr), 0);

`ifdef INSTR_FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      if (i < 15) begin
        chk("to_wait_err", 32'(err), 0);
        chk("to_wait_rd", 32'(mem_rd), 1);
      end else begin
        chk("to_err", 32'(err), 1);
        chk("to_drop_rd", 32'(mem_rd), 0);
      end
    end
    step(0, 8'h00, 0, 0, 8'h00);
    chk("to_retry_rd", 32'(mem_rd), 1);
    chk("to_retry_addr", 32'(mem_addr), 0);
    step(1, 8'h6A, 0, 0, 8'h00);
    chk("to_ack_op", 32'(op), 3'd3);
    chk("to_ack_operand", 32'(operand), 5'h0A);
    chk("to_sticky", 32'(err), 1);
`else
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      chk("nto_rd", 32'(mem_rd), 1);
      chk("nto_err", 32'(err), 0);
    end
    step(1, 8'h6A, 0, 0, 8'h00);
    chk("nto_ack_op", 32'(op), 3'd3);
    chk("nto_ack_operand", 32'(operand), 5'h0A);
    chk("nto_ack_err", 32'(err), 0);
`endif
    step(0, 8'h00, 1, 0, 8'h00);

    for (int c = 0; c < 3000; c++) begin
      automatic logic       a;
      automatic logic       e;
      automatic logic       j;
      automatic logic [7:0] d;
      automatic logic [7:0] ja;
      automatic logic       quiet;
      quiet = ((c % 500) >= 470);
      if (mem_rd) begin
        a = !quiet && ($urandom_range(0, 3) == 0);
        d = mem[mem_addr];
      end else begin
        a = ($urandom_range(0, 5) == 0);
        d = 8'($urandom);
      end
      e = ($urandom_range(0, 2) == 0);
      j = !quiet && ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       ja = 8'hFF;
        1:       ja = 8'hFE;
        default: ja = 8'($urandom);
      endcase
      if ((c % 400) == 399) begin
        clr = 1'b1;
        step(a, d, e, j, ja);
        clr = 1'b0;
      end else begin
        step(a, d, e, j, ja);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
